// File: rtl/idct_row_collector_if.sv
// Beat-in / row-out bus for the IDCT row collector.
// The master drives coefficient beats; the slave presents assembled rows.
interface idct_row_collector_if #(
  parameter int COEF_W = 16
);
  logic                   i_start;
  logic [1:0]             i_transize;
  logic                   i_valid;
  logic [4*COEF_W-1:0]    i_data;
  logic                   o_ready;
  logic                   o_valid;
  logic [32*COEF_W-1:0]   o_data;
  logic [1:0]             o_transize;
  logic [4:0]             o_row_idx;
  logic                   o_last;
  logic                   o_busy;
  logic                   o_err;

  modport master (
    output i_start, i_transize, i_valid, i_data,
    input  o_ready, o_valid, o_data, o_transize,
    input  o_row_idx, o_last, o_busy, o_err
  );

  modport slave (
    input  i_start, i_transize, i_valid, i_data,
    output o_ready, o_valid, o_data, o_transize,
    output o_row_idx, o_last, o_busy, o_err
  );
endinterface

// File: rtl/idct_row_collector.sv
// Collects 4-coefficient beats into zero-padded 32-lane IDCT rows.
// Define IDCT_ROW_COLLECTOR_CHK_EN to build the sticky protocol checker.
module idct_row_collector #(
  parameter int COEF_W     = 16,
  parameter int BEAT_LANES = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  idct_row_collector_if.slave  bus
);
  localparam int BW    = BEAT_LANES * COEF_W;
  localparam int ROW_W = 32 * COEF_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state;
  logic [2:0]         beat_cnt;
  logic [4:0]         row_cnt;
  logic [ROW_W-1:0]   asm_q;
  logic [ROW_W-1:0]   merged;
  logic [ROW_W-1:0]   data_q;
  logic [1:0]         ts_q;
  logic [4:0]         row_idx_q;
  logic               ready_q;
  logic               busy_q;
  logic               valid_q;
  logic               last_q;
  logic [2:0]         bpr_m1;
  logic [4:0]         n_m1;

  always_comb begin
    bpr_m1 = 3'd0;
    n_m1   = 5'd3;
    unique case (ts_q)
      2'd0: begin bpr_m1 = 3'd0; n_m1 = 5'd3;  end
      2'd1: begin bpr_m1 = 3'd1; n_m1 = 5'd7;  end
      2'd2: begin bpr_m1 = 3'd3; n_m1 = 5'd15; end
      2'd3: begin bpr_m1 = 3'd7; n_m1 = 5'd31; end
    endcase
  end

  // current beat dropped into its slot; lanes beyond N stay zero
  always_comb begin
    merged = asm_q;
    for (int k = 0; k < 8; k++) begin
      if (beat_cnt == 3'(k))
        merged[k*BW +: BW] = bus.i_data;
    end
    for (int l = 0; l < 32; l++) begin
      if (5'(l) > n_m1)
        merged[l*COEF_W +: COEF_W] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      row_cnt   <= '0;
      asm_q     <= '0;
      data_q    <= '0;
      ts_q      <= '0;
      row_idx_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            ts_q     <= bus.i_transize;
            beat_cnt <= '0;
            row_cnt  <= '0;
            asm_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b1;
            state    <= FILL;
          end
        end
        FILL: begin
          if (bus.i_valid) begin
            if (beat_cnt == bpr_m1) begin
              data_q    <= merged;
              valid_q   <= 1'b1;
              row_idx_q <= row_cnt;
              last_q    <= (row_cnt == n_m1);
              beat_cnt  <= '0;
              asm_q     <= '0;
              if (row_cnt == n_m1) begin
                row_cnt <= '0;
                ready_q <= 1'b0;
                busy_q  <= 1'b0;
                state   <= IDLE;
              end else begin
                row_cnt <= row_cnt + 5'd1;
              end
            end else begin
              asm_q    <= merged;
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_data     = data_q;
  assign bus.o_transize = ts_q;
  assign bus.o_row_idx  = row_idx_q;
  assign bus.o_last     = last_q;

`ifdef IDCT_ROW_COLLECTOR_CHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if ((state == IDLE && bus.i_valid) ||
                 (state == FILL && bus.i_start)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif
endmodule

// File: tb/tb_idct_row_collector.sv
// Directed bench for idct_row_collector: vector table plus
// hand-written block, reset, chaining and protocol sequences.
module tb_idct_row_collector;
  logic clk = 1'b0;
  logic rstn;
  int   tests = 0;
  int   fails = 0;

  idct_row_collector_if #(.COEF_W(16)) bus ();

  idct_row_collector #(.COEF_W(16), .BEAT_LANES(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          start;
    bit [1:0]    ts;
    bit          valid;
    logic [63:0] data;
    bit          e_ready;
    bit          e_valid;
    bit [4:0]    e_row;
    bit          e_last;
    logic [63:0] e_lo;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] coef(int seed, int r, int k, bit ff);
    if (ff && k < 4) return 16'hFFFF;
    return 16'(seed * 1024 + r * 32 + k + 1);
  endfunction

  task automatic send_block(input bit [1:0] ts, input int seed,
                            input bit gaps, input bit ff,
                            input bit do_start, input int max_beats);
    int n;
    int bpr;
    int beats;
    int pulses;
    int ngap;
    logic [511:0] exp_row;
    logic [63:0]  d;
    logic [15:0]  c;
    n = 4 << ts;
    bpr = n / 4;
    beats = 0;
    pulses = 0;
    if (do_start) begin
      bus.i_start = 1'b1;
      bus.i_transize = ts;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      bus.i_transize = ~ts;
      chk("start_ready", 512'(bus.o_ready), 512'(1));
      chk("start_ts", 512'(bus.o_transize), 512'(ts));
    end
    for (int r = 0; r < n; r++) begin
      exp_row = '0;
      for (int b = 0; b < bpr; b++) begin
        if (max_beats >= 0 && beats == max_beats) return;
        if (gaps) begin
          ngap = $urandom_range(0, 2);
          repeat (ngap) begin
            bus.i_valid = 1'b0;
            @(posedge clk); #1;
            chk("gap_valid", 512'(bus.o_valid), 512'(0));
          end
        end
        for (int j = 0; j < 4; j++) begin
          c = coef(seed, r, b * 4 + j, ff);
          d[j*16 +: 16] = c;
          exp_row[(b*4+j)*16 +: 16] = c;
        end
        bus.i_valid = 1'b1;
        bus.i_data = d;
        @(posedge clk); #1;
        beats++;
        if (b == bpr - 1) begin
          pulses++;
          chk("row_valid", 512'(bus.o_valid), 512'(1));
          chk("row_data", bus.o_data, exp_row);
          chk("row_idx", 512'(bus.o_row_idx), 512'(r));
          chk("row_last", 512'(bus.o_last), 512'(r == n - 1));
        end else begin
          chk("mid_valid", 512'(bus.o_valid), 512'(0));
        end
      end
    end
    bus.i_valid = 1'b0;
    chk("ready_after_last", 512'(bus.o_ready), 512'(0));
    chk("pulses", 512'(pulses), 512'(n));
  endtask

  initial begin
    bit exp_err;
`ifdef IDCT_ROW_COLLECTOR_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    tbl[0] = '{1, 0, 0, 64'h0, 1, 0, 0, 0, 64'h0};
    tbl[1] = '{0, 0, 1, 64'h0004_0003_0002_0001,
               1, 1, 0, 0, 64'h0004_0003_0002_0001};
    tbl[2] = '{0, 0, 1, 64'h0008_0007_0006_0005,
               1, 1, 1, 0, 64'h0008_0007_0006_0005};
    tbl[3] = '{0, 0, 1, 64'h000c_000b_000a_0009,
               1, 1, 2, 0, 64'h000c_000b_000a_0009};
    tbl[4] = '{0, 0, 1, 64'h0010_000f_000e_000d,
               0, 1, 3, 1, 64'h0010_000f_000e_000d};
    tbl[5] = '{0, 0, 0, 64'h0,
               0, 0, 3, 1, 64'h0010_000f_000e_000d};

    rstn = 1'b0;
    bus.i_start = 1'b0;
    bus.i_transize = '0;
    bus.i_valid = 1'b0;
    bus.i_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 512'(bus.o_ready), 512'(0));
    chk("rst_valid", 512'(bus.o_valid), 512'(0));
    chk("rst_busy", 512'(bus.o_busy), 512'(0));
    chk("rst_data", bus.o_data, 512'(0));
    chk("rst_err", 512'(bus.o_err), 512'(0));
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      bus.i_start = tbl[i].start;
      bus.i_transize = tbl[i].ts;
      bus.i_valid = tbl[i].valid;
      bus.i_data = tbl[i].data;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_ready", i), 512'(bus.o_ready),
          512'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_valid", i), 512'(bus.o_valid),
          512'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_row", i), 512'(bus.o_row_idx),
          512'(tbl[i].e_row));
      chk($sformatf("tbl%0d_last", i), 512'(bus.o_last),
          512'(tbl[i].e_last));
      chk($sformatf("tbl%0d_data", i), bus.o_data,
          512'(tbl[i].e_lo));
    end
    bus.i_valid = 1'b0;

    // 8x8 with 0xFFFF first beats, then 16x16 must carry no leftovers
    send_block(2'd1, 1, 1'b0, 1'b1, 1'b1, -1);
    send_block(2'd2, 2, 1'b0, 1'b0, 1'b1, -1);

    send_block(2'd3, 8, 1'b1, 1'b0, 1'b1, -1);

    // chain: start in the cycle of the last 8x8 row pulse
    send_block(2'd1, 3, 1'b0, 1'b0, 1'b1, -1);
    bus.i_start = 1'b1;
    bus.i_transize = 2'd0;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    chk("chain_ready", 512'(bus.o_ready), 512'(1));
    chk("chain_ts", 512'(bus.o_transize), 512'(0));
    send_block(2'd0, 4, 1'b0, 1'b0, 1'b0, -1);

    // reset two beats into row 5 of a 16x16 block
    send_block(2'd2, 5, 1'b0, 1'b0, 1'b1, 22);
    bus.i_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("mrst_valid", 512'(bus.o_valid), 512'(0));
    chk("mrst_ready", 512'(bus.o_ready), 512'(0));
    chk("mrst_busy", 512'(bus.o_busy), 512'(0));
    chk("mrst_data", bus.o_data, 512'(0));
    chk("mrst_row", 512'(bus.o_row_idx), 512'(0));
    chk("mrst_ts", 512'(bus.o_transize), 512'(0));
    chk("mrst_last", 512'(bus.o_last), 512'(0));
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("mrst_no_row5", 512'(bus.o_valid), 512'(0));
    send_block(2'd0, 6, 1'b0, 1'b0, 1'b1, -1);

    bus.i_valid = 1'b1;
    bus.i_data = 64'h1234;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    chk("err_idle_valid", 512'(bus.o_err), 512'(exp_err));
    chk("idle_drop_valid", 512'(bus.o_valid), 512'(0));
    repeat (100) @(posedge clk);
    #1;
    chk("err_sticky", 512'(bus.o_err), 512'(exp_err));

    send_block(2'd1, 7, 1'b0, 1'b0, 1'b1, 0);
    bus.i_start = 1'b1;
    bus.i_transize = 2'd3;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    chk("fill_start_ts", 512'(bus.o_transize), 512'(1));
    chk("fill_start_ready", 512'(bus.o_ready), 512'(1));
    send_block(2'd1, 7, 1'b0, 1'b0, 1'b0, -1);
    chk("err_final", 512'(bus.o_err), 512'(exp_err));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/idct_row_collector.md
Name: idct_row_collector

Overview:
- Input staging stage directly upstream of the inverse-transform input permutation network.
- Collects dequantised coefficients arriving 4 per beat over a valid/ready bus and assembles one full row of N = 4/8/16/32 coefficients.
- Presents each complete row as a 32-lane, zero-padded vector with a one-cycle valid pulse, plus the transform size, row index and last-row flag.
- Sequences exactly N rows per block, then returns to idle.

Parameters:
- COEF_W, 16, width of one coefficient; output lane k occupies o_data[COEF_W*k+COEF_W-1 : COEF_W*k].
- BEAT_LANES, 4, coefficients per input beat; fixed at 4, other values unsupported.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rstn  in  1  reset, synchronous, active-low.
- i_start  in  1  one-cycle pulse; begins a block and latches i_transize.
- i_transize  in  2  0:4x4, 1:8x8, 2:16x16, 3:32x32; sampled only with i_start.
- i_valid  in  1  input beat valid.
- i_data  in  4*COEF_W  four coefficients; lane 0 in the LSBs, lane j = row position beat*4+j.
- o_ready  out  1  beat accepted when i_valid && o_ready.
- o_valid  out  1  one-cycle pulse; a complete row is on o_data.
- o_data  out  32*COEF_W  row coefficients in natural order; lanes >= N are 0.
- o_transize  out  2  latched size of the current block.
- o_row_idx  out  5  row number (0..N-1) of the row on o_data.
- o_last  out  1  qualifies o_valid; the row is row N-1.
- o_busy  out  1  high in FILL.
- o_err  out  1  sticky protocol error flag (see Optional Feature).

Behaviour:
- Reset (rstn=0 at a clk edge) takes effect that cycle, including mid-block:
  - state=IDLE; beat_cnt=0, row_cnt=0.
  - o_ready=0, o_valid=0, o_last=0, o_busy=0, o_err=0.
  - o_data=0, o_transize=0, o_row_idx=0, assembly register=0.
  - A partial row is discarded and no o_valid is issued for it.
- N = 4<<transize. Beats per row: BPR = N/4, i.e. 1, 2, 4 or 8.
- IDLE:
  - o_ready=0, o_busy=0. i_valid is ignored.
  - i_start=1: latch o_transize<=i_transize, clear beat_cnt, row_cnt and the assembly register, go to FILL.
  - o_ready is 1 from the next cycle.
- FILL, o_ready=1, o_busy=1. On an accepted beat:
  - Lanes beat_cnt*4 .. beat_cnt*4+3 of the assembly register <= i_data lanes 0..3.
  - If beat_cnt < BPR-1: beat_cnt++.
  - If beat_cnt == BPR-1:
    - Next cycle: o_data = assembly register merged with the current beat; lanes >= N forced 0. o_valid=1, o_row_idx=row_cnt, o_last=(row_cnt==N-1).
    - beat_cnt<=0. Assembly register cleared to 0, so no stale data carries into the next row.
    - If row_cnt == N-1: row_cnt<=0, state<=IDLE, o_ready=0 from the next cycle. Otherwise row_cnt++.
- FILL with no accepted beat: counters hold; o_valid=0.
- Latency: o_valid rises exactly 1 cycle after the last beat of a row is accepted. o_data, o_row_idx and o_last hold until the next row load.
- Back-to-back:
  - Beats may arrive every cycle. For 4x4 (BPR=1) o_valid may pulse on consecutive cycles.
  - The final o_valid of a block coincides with the first IDLE cycle. An i_start in that same cycle is honoured, giving 1 idle cycle between blocks.
- No downstream backpressure: the consumer must take each row in its o_valid cycle.
- i_start while in FILL: ignored; the block continues with the latched size.
- Simultaneous i_start and i_valid in IDLE: the start is taken and the beat is dropped (o_ready was 0).
- i_transize changes outside an i_start cycle: no effect.

Optional Feature:
- Macro IDCT_ROW_COLLECTOR_CHK_EN.
- Defined: o_err sets to 1 one cycle after either of these events, and stays set until reset:
  - i_valid=1 in IDLE;
  - i_start=1 in FILL.
- Not defined: no checking logic is built and o_err is tied to 0.
- Datapath behaviour is identical in both builds.

Test Plan:
- 4x4 block: i_start with transize=0, then 4 consecutive beats with lane values r*4+j+1. Required:
  - 4 o_valid pulses on consecutive cycles, each 1 cycle after its beat;
  - row 0 o_data lanes 0..3 = 1,2,3,4 and lanes 4..31 = 0;
  - o_row_idx = 0,1,2,3, with o_last high only on row 3.
- 32x32 block with random i_valid gaps and 256 beats total. Required:
  - exactly 32 o_valid pulses;
  - each o_data equals the 32 coefficients sent in order;
  - o_ready=0 on the cycle after the 256th beat.
- 8x8 row: send beat 0 = 0xFFFF x4, then a 16x16 block. Required:
  - first 8x8 o_data lanes 8..31 = 0;
  - the later 16x16 rows carry no leftover 0xFFFF in lanes 16..31.
- Reset mid-block: 16x16 block, assert rstn=0 after 2 of the 4 beats of row 5. Required:
  - all outputs 0 the next cycle and no o_valid for row 5;
  - a new 4x4 block afterwards produces o_row_idx starting at 0.
- Protocol errors, CHK_EN defined: i_valid=1 in IDLE. Required: o_err=1 next cycle and still 1 after 100 cycles; i_start during FILL leaves o_transize unchanged. Without the macro the same stimulus gives o_err=0.
- Block chaining: i_start in the same cycle as the last o_valid of an 8x8 block. Required: the new block starts, o_ready=1 after 1 cycle, and o_transize updates to the new size.
